// File: rtl/cobs_stream_decoder_if.sv
// Byte-wide AXI-Stream style link carrying encoded or decoded COBS traffic.
`timescale 1ns/1ps
interface cobs_stream_decoder_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/cobs_stream_decoder.sv
// Streaming COBS decoder: 0x00-delimited encoded frames in, raw payload out with
// tlast on the final byte and tuser flagging truncated or over-length frames.
`timescale 1ns/1ps
module cobs_stream_decoder #(
    parameter int unsigned MAX_FRAME_BYTES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cobs_stream_decoder_if.slave  s_axis,
    cobs_stream_decoder_if.master m_axis
);
    typedef enum logic {ST_CODE, ST_DATA} state_t;

    localparam int unsigned CW = (MAX_FRAME_BYTES == 0) ? 1 : $clog2(MAX_FRAME_BYTES + 1);

    state_t        state_q, state_d;
    logic [7:0]    remaining_q, remaining_d;
    logic          pend_valid_q, pend_valid_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          zero_owed_q, zero_owed_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          out_user_q, out_user_d;

    logic       s_ready, accept, at_limit;
    logic       do_push, do_delim, trunc_err;
    logic [7:0] push_byte, x;
    logic       unused_in;

    assign unused_in = ^{s_axis.tlast, s_axis.tuser};

    assign s_ready       = !out_valid_q || m_axis.tready;
    assign s_axis.tready = s_ready;
    assign accept        = s_axis.tvalid && s_ready;
    assign x             = s_axis.tdata;
    assign at_limit      = (MAX_FRAME_BYTES != 0) && (count_q == CW'(MAX_FRAME_BYTES));

    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tlast  = out_last_q;
    assign m_axis.tuser  = out_user_q;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        zero_owed_d  = zero_owed_q;
        err_d        = err_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_user_d   = out_user_q;
        do_push      = 1'b0;
        push_byte    = '0;
        do_delim     = 1'b0;
        trunc_err    = 1'b0;

        if (out_valid_q && m_axis.tready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                ST_CODE: begin
                    if (x == 8'h00) begin
                        do_delim = 1'b1;
                    end else begin
                        // The implicit zero of the previous group is only materialised
                        // once another group proves the frame continues.
                        do_push     = zero_owed_q;
                        push_byte   = 8'h00;
                        remaining_d = x - 8'd1;
                        zero_owed_d = (x != 8'hFF);
                        state_d     = (x > 8'd1) ? ST_DATA : ST_CODE;
                    end
                end
                ST_DATA: begin
                    if (x != 8'h00) begin
                        do_push     = 1'b1;
                        push_byte   = x;
                        remaining_d = remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            state_d = ST_CODE;
                        end
                    end else begin
                        trunc_err = 1'b1;
                        do_delim  = 1'b1;
                    end
                end
                default: state_d = ST_CODE;
            endcase
        end

        if (do_push) begin
            if (at_limit) begin
                err_d = 1'b1;
            end else begin
                if (pend_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pend_data_q;
                    out_last_d  = 1'b0;
                    out_user_d  = 1'b0;
                end
                pend_data_d  = push_byte;
                pend_valid_d = 1'b1;
                count_d      = count_q + CW'(1);
            end
        end

        if (do_delim) begin
            if (pend_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = pend_data_q;
                out_last_d  = 1'b1;
                out_user_d  = err_q || trunc_err;
            end
            pend_valid_d = 1'b0;
            zero_owed_d  = 1'b0;
            err_d        = 1'b0;
            count_d      = '0;
            state_d      = ST_CODE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CODE;
            remaining_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            zero_owed_q  <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_user_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            zero_owed_q  <= zero_owed_d;
            err_q        <= err_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_user_q   <= out_user_d;
        end
    end
endmodule

// File: tb/tb_cobs_stream_decoder.sv
// Bench for cobs_stream_decoder: an unlimited and a 2-byte-limited instance share
// each stimulus stream and are compared against a frame-level COBS reference decoder.
`timescale 1ns/1ps
module tb_cobs_stream_decoder;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cobs_stream_decoder_if sif0 ();
    cobs_stream_decoder_if mif0 ();
    cobs_stream_decoder_if sif1 ();
    cobs_stream_decoder_if mif1 ();

    cobs_stream_decoder #(.MAX_FRAME_BYTES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .s_axis(sif0), .m_axis(mif0));
    cobs_stream_decoder #(.MAX_FRAME_BYTES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .s_axis(sif1), .m_axis(mif1));

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    bit gaps = 0;
    logic [7:0] stim[$];
    logic [9:0] exp0[$], exp1[$], got0[$], got1[$];
    logic       stall0 = 0, stall1 = 0;
    logic [10:0] hold0, hold1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Downstream ready: 0 always, 1 toggling, 2 random, 3 held low.
    initial begin
        logic r;
        r = 1'b1;
        mif0.tready = 1'b1;
        mif1.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: r = 1'b1;
                1: r = ~r;
                2: r = 1'($urandom_range(0, 1));
                default: r = 1'b0;
            endcase
            mif0.tready = r;
            mif1.tready = r;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("s_tready0", sif0.tready, !(mif0.tvalid && !mif0.tready));
            if (stall0) chk("hold0", {mif0.tvalid, mif0.tlast, mif0.tuser, mif0.tdata}, hold0);
            if (mif0.tvalid && mif0.tready) got0.push_back({mif0.tlast, mif0.tuser, mif0.tdata});
            stall0 <= mif0.tvalid && !mif0.tready;
            hold0  <= {mif0.tvalid, mif0.tlast, mif0.tuser, mif0.tdata};
        end else begin
            stall0 <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("s_tready1", sif1.tready, !(mif1.tvalid && !mif1.tready));
            if (stall1) chk("hold1", {mif1.tvalid, mif1.tlast, mif1.tuser, mif1.tdata}, hold1);
            if (mif1.tvalid && mif1.tready) got1.push_back({mif1.tlast, mif1.tuser, mif1.tdata});
            stall1 <= mif1.tvalid && !mif1.tready;
            hold1  <= {mif1.tvalid, mif1.tlast, mif1.tuser, mif1.tdata};
        end else begin
            stall1 <= 1'b0;
        end
    end

    // Reference: split at 0x00, decode each frame group by group, apply the byte limit.
    task automatic model(input int sel, input int unsigned maxb);
        logic [7:0] fr[$];
        logic [7:0] dec[$];
        bit err;
        int i;
        int code;
        foreach (stim[n]) begin
            if (stim[n] != 8'h00) begin
                fr.push_back(stim[n]);
            end else begin
                dec.delete();
                err = 0;
                i = 0;
                while (i < fr.size() && !err) begin
                    code = int'(fr[i]);
                    i++;
                    for (int k = 1; k < code; k++) begin
                        if (i >= fr.size()) begin
                            err = 1;
                            break;
                        end
                        dec.push_back(fr[i]);
                        i++;
                    end
                    if (!err && code != 255 && i < fr.size()) dec.push_back(8'h00);
                end
                if (maxb != 0 && dec.size() > maxb) begin
                    while (dec.size() > maxb) void'(dec.pop_back());
                    err = 1;
                end
                foreach (dec[j]) begin
                    if (sel == 0) exp0.push_back({j == dec.size() - 1, (j == dec.size() - 1) && err, dec[j]});
                    else          exp1.push_back({j == dec.size() - 1, (j == dec.size() - 1) && err, dec[j]});
                end
                fr.delete();
            end
        end
    endtask

    task automatic drive(input int sel);
        foreach (stim[n]) begin
            int w;
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            if (sel == 0) begin
                sif0.tvalid = 1'b1; sif0.tdata = stim[n]; sif0.tlast = 1'($urandom_range(0, 1));
            end else begin
                sif1.tvalid = 1'b1; sif1.tdata = stim[n]; sif1.tuser = 1'($urandom_range(0, 1));
            end
            w = 0;
            forever begin
                @(negedge clk);
                if ((sel == 0 ? sif0.tready : sif1.tready) || w >= 500) break;
                w++;
            end
            chk(sel == 0 ? "drv_wait0" : "drv_wait1", w < 500, 1);
            @(posedge clk);
            #1;
            if (sel == 0) sif0.tvalid = 1'b0;
            else          sif1.tvalid = 1'b0;
        end
    endtask

    task automatic drain_and_compare();
        int w;
        w = 0;
        while ((got0.size() < exp0.size() || got1.size() < exp1.size() || mif0.tvalid || mif1.tvalid)
               && w < 3000) begin
            @(posedge clk);
            w++;
        end
        chk("drain", w < 3000, 1);
        repeat (4) @(posedge clk);
        chk("count0", got0.size(), exp0.size());
        chk("count1", got1.size(), exp1.size());
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) chk("beat0", got0[i], exp0[i]);
        for (int i = 0; i < got1.size() && i < exp1.size(); i++) chk("beat1", got1[i], exp1[i]);
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic run();
        model(0, 0);
        model(1, 2);
        fork
            drive(0);
            drive(1);
        join
        drain_and_compare();
    endtask

    task automatic reset_checks();
        chk("rst_valid0", mif0.tvalid, 0); chk("rst_data0", mif0.tdata, 0);
        chk("rst_last0", mif0.tlast, 0);   chk("rst_user0", mif0.tuser, 0);
        chk("rst_valid1", mif1.tvalid, 0); chk("rst_data1", mif1.tdata, 0);
        chk("rst_last1", mif1.tlast, 0);   chk("rst_user1", mif1.tuser, 0);
        chk("rst_sready0", sif0.tready, 1); chk("rst_sready1", sif1.tready, 1);
    endtask

    // Append one COBS-encoded frame of the payload plus delimiter, optionally cut short.
    task automatic encode_append(input logic [7:0] pl[$], input bit trunc);
        logic [7:0] enc[$];
        int cpos;
        int code;
        int cut;
        cpos = 0; enc.push_back(8'h00); code = 1;
        foreach (pl[i]) begin
            if (pl[i] == 8'h00) begin
                enc[cpos] = 8'(code); cpos = enc.size(); enc.push_back(8'h00); code = 1;
            end else begin
                enc.push_back(pl[i]); code++;
                if (code == 255) begin
                    enc[cpos] = 8'(code); cpos = enc.size(); enc.push_back(8'h00); code = 1;
                end
            end
        end
        enc[cpos] = 8'(code);
        if (trunc && enc.size() > 1) begin
            cut = $urandom_range(1, (enc.size() - 1 < 3) ? enc.size() - 1 : 3);
            repeat (cut) void'(enc.pop_back());
        end
        foreach (enc[i]) stim.push_back(enc[i]);
        stim.push_back(8'h00);
    endtask

    initial begin
        logic [7:0] pl[$];
        int len;
        reset_n = 1'b0;
        sif0.tvalid = 0; sif0.tdata = 0; sif0.tlast = 0; sif0.tuser = 0;
        sif1.tvalid = 0; sif1.tdata = 0; sif1.tlast = 0; sif1.tuser = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        reset_n = 1'b1;
        @(posedge clk);

        stim = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        run();
        stim = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
        run();
        stim = '{8'h04, 8'hAA, 8'hBB, 8'h00, 8'h02, 8'h55, 8'h00};
        run();
        stim = '{8'hFF};
        for (int b = 1; b <= 254; b++) stim.push_back(8'(b));
        stim.push_back(8'h01);
        stim.push_back(8'h00);
        run();
        stim = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h00};
        run();

        rdy_mode = 1;
        stim = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        fork
            run();
            begin
                repeat (5) @(posedge clk);
                rdy_mode = 3;
                repeat (5) @(posedge clk);
                rdy_mode = 1;
            end
        join

        rdy_mode = 0;
        stim = '{8'h04, 8'h01};
        fork
            drive(0);
            drive(1);
        join
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_checks();
        reset_n = 1'b1;
        stim = '{8'h02, 8'h77, 8'h00};
        run();

        gaps = 1;
        rdy_mode = 2;
        for (int it = 0; it < 30; it++) begin
            stim.delete();
            repeat ($urandom_range(1, 3)) begin
                pl.delete();
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 520) : $urandom_range(0, 12);
                repeat (len) pl.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                encode_append(pl, $urandom_range(0, 4) == 0);
                if ($urandom_range(0, 5) == 0) stim.push_back(8'h00);
            end
            run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
